// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the UART byte transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_tx_pkg;

    // Frame sequencer states. PARITY is only reachable in parity-enabled builds.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and flags the last cycle of each period.
// Latency: bit_done is a combinational decode of the registered count.
// Backpressure: none; clear restarts the period, en gates counting.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clear      restart the period at 0 (pulsed when a byte is accepted)
//   en         count while a frame is in progress
//   bit_done   high on the final cycle of the current bit period
module uart_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Explicit wrap so non-power-of-two periods work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bit_done = en && (cnt == CNT_MAX);

endmodule

// File: rtl/uart_byte_transmitter.sv
// Serialises one byte per valid/ready handshake into start, LSB-first data, [parity], stop.
// Latency: start bit on the line the cycle after acceptance; frame = bits * CLKS_PER_BIT cycles.
// Backpressure: tx_ready high only in IDLE; tx_valid/tx_data ignored while a frame is in flight.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset (line forced high at once)
//   tx_data     byte to send, sampled on the accepting edge only
//   tx_valid    tx_data is valid
//   tx_ready    block can accept a byte (state == IDLE)
//   tx_serial   registered serial line, idles high
//   tx_busy     frame in progress (state != IDLE)
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit after the MSB.
module uart_byte_transmitter
    import uart_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [DATA_W-1:0] shift_q;
    logic [IDX_W-1:0]  bit_idx;
    logic              serial_q;
    logic              serial_nxt;
    logic              shift_step;
    logic              idx_inc;
    logic              accept;
    logic              bit_done;
`ifdef UART_TX_PARITY_EN
    logic              parity_q;
`endif

    assign tx_ready  = (state == IDLE);
    assign tx_busy   = (state != IDLE);
    assign tx_serial = serial_q;
    assign accept    = tx_valid && tx_ready;

    uart_tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .en       (tx_busy),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the next line level; the line itself is always a flop.
    // Each data bit is presented from shift_q[0] at the moment its period begins,
    // and the register shifts in the same edge so the next bit is ready.
    always_comb begin
        state_nxt  = state;
        serial_nxt = serial_q;
        shift_step = 1'b0;
        idx_inc    = 1'b0;
        case (state)
            IDLE: begin
                serial_nxt = LINE_IDLE;
                if (tx_valid) begin
                    state_nxt  = START;
                    serial_nxt = LINE_START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_nxt  = DATA;
                    serial_nxt = shift_q[0];
                    shift_step = 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt  = PARITY;
                        serial_nxt = parity_q;
`else
                        state_nxt  = STOP;
                        serial_nxt = LINE_IDLE;
`endif
                    end else begin
                        serial_nxt = shift_q[0];
                        shift_step = 1'b1;
                        idx_inc    = 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_nxt  = STOP;
                    serial_nxt = LINE_IDLE;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    state_nxt  = IDLE;
                    serial_nxt = LINE_IDLE;
                end
            end
            default: begin
                state_nxt  = IDLE;
                serial_nxt = LINE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            serial_q <= LINE_IDLE;
            shift_q  <= '0;
            bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            serial_q <= serial_nxt;
            if (accept) begin
                shift_q  <= tx_data;
                bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
                // Even parity over the byte as accepted, so later tx_data changes cannot leak in.
                parity_q <= ^tx_data;
`endif
            end else begin
                if (shift_step) begin
                    shift_q <= {1'b0, shift_q[DATA_W-1:1]};
                end
                if (idx_inc) begin
                    bit_idx <= bit_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_transmitter.sv
// Directed bench for uart_byte_transmitter (CLKS_PER_BIT=4, DATA_W=8).
// Frame bits are derived here from the byte; parity build is followed via UART_TX_PARITY_EN.
module tb_uart_byte_transmitter;

    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = DW + 3;
`else
    localparam int FRAME_BITS = DW + 2;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic          clk;
    logic          rst;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_serial;
    logic          tx_busy;
    logic          clk_run;
    int            cyc;
    int            n_checks;
    int            n_fail;

    uart_byte_transmitter #(
        .DATA_W       (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy)
    );

    initial clk = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at the first negedge after acceptance; checks every cycle of the frame
    // and the idle cycle that follows. Optionally pulses tx_valid/0xFF mid-frame.
    task automatic check_frame(input logic [DW-1:0] d, input bit glitch);
        logic [FRAME_BITS-1:0] exp;
        int busy_cnt;
        exp = '0;
        exp[0] = 1'b0;
        for (int i = 0; i < DW; i++) exp[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        exp[DW+1] = ^d;
`endif
        exp[FRAME_BITS-1] = 1'b1;
        busy_cnt = 0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            if (glitch && k == 10) begin
                tx_data  = 8'hFF;
                tx_valid = 1'b1;
            end
            if (glitch && k == 14) tx_valid = 1'b0;
            check($sformatf("d%02h_bit%0d_cyc%0d", d, k / CPB, k), tx_serial, exp[k / CPB]);
            if (tx_busy && !tx_ready) busy_cnt++;
            @(negedge clk);
        end
        check($sformatf("d%02h_frame_len", d), busy_cnt, FRAME_CYC);
        check($sformatf("d%02h_idle_line", d), tx_serial, 1);
        check($sformatf("d%02h_idle_ready", d), tx_ready, 1);
        check($sformatf("d%02h_idle_busy", d), tx_busy, 0);
    endtask

    task automatic send_byte(input logic [DW-1:0] d, input bit glitch);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check_frame(d, glitch);
    endtask

    initial begin
        int t1;
        int t2;
        int extra;
        n_checks = 0;
        n_fail   = 0;
        clk_run  = 1'b0;
        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;

        // 1: asynchronous reset with no clock running
        #1 rst = 1'b1;
        #1;
        check("rst_line", tx_serial, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", tx_busy, 0);
        clk_run = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_line", tx_serial, 1);

        // 2: single frame 0xA5
        send_byte(8'hA5, 1'b0);

        // 3: back-to-back with tx_valid held; data changes mid-frame
        @(negedge clk);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        t1 = cyc;
        tx_data = 8'hFF;
        check_frame(8'h00, 1'b0);
        t2 = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (tx_busy) begin
                t2 = cyc;
                break;
            end
        end
        tx_valid = 1'b0;
        check("b2b_start_period", t2 - t1, FRAME_CYC + 1);
        check_frame(8'hFF, 1'b0);

        // 4: tx_valid pulsed during a frame must be ignored
        send_byte(8'h3C, 1'b1);
        extra = 0;
        for (int n = 0; n < 60; n++) begin
            if (tx_busy || !tx_serial) extra++;
            @(negedge clk);
        end
        check("no_ghost_frame", extra, 0);

        // 5: reset during data bit 3 of 0x81, then a clean frame
        @(negedge clk);
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (17) @(negedge clk);
        check("pre_rst_bit3", tx_serial, 0);
        rst = 1'b1;
        #1;
        check("midrst_line", tx_serial, 1);
        check("midrst_ready", tx_ready, 1);
        check("midrst_busy", tx_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("after_rst_line", tx_serial, 1);
        send_byte(8'h42, 1'b0);

`ifdef UART_TX_PARITY_EN
        // 6: parity bits 0 (0xA5) and 1 (0x07), 44-cycle frames
        send_byte(8'hA5, 1'b0);
        send_byte(8'h07, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
